// File: rtl/seq_check_stream.sv
// Symbol-by-symbol round checker for the memory game.
// Compares the player's symbol stream against the golden sequence, enforces
// a per-symbol idle timeout and a lives budget, and raises the one-cycle
// block-reset pulses that the top-level game FSM consumes.
module seq_check_stream #(
  parameter int SYM_W      = 2,
  parameter int MAX_ROUNDS = 16,
  parameter int LIVES      = 3,
  parameter int TIMEOUT    = 1024,
  parameter int CTR_W      = $clog2(MAX_ROUNDS)
) (
  input  logic                        clk,
  input  logic                        rst_check,
  input  logic                        en_check,
  input  logic [CTR_W-1:0]            round_ctr_in,
  input  logic [SYM_W*MAX_ROUNDS-1:0] seq_mem,
  input  logic                        sym_valid,
  input  logic [SYM_W-1:0]            sym_in,
  output logic                        sym_ready,
  output logic [CTR_W-1:0]            sym_idx,
  output logic [CTR_W-1:0]            round_ctr_out,
  output logic [3:0]                  lives_left,
  output logic                        complete_check,
  output logic                        fail_check,
  output logic                        timeout_check,
  output logic                        game_complete,
  output logic                        game_over,
  output logic                        rst_wait,
  output logic                        rst_idle,
  output logic                        rst_display
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CTR_W-1:0] LAST_ROUND = CTR_W'(MAX_ROUNDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   round_q, round_d;         // round being checked (R)
  logic [CTR_W-1:0]   sym_idx_q, sym_idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CTR_W-1:0]   round_out_q, round_out_d;
  logic [3:0]         lives_q, lives_d;
  logic               game_complete_q, game_complete_d;
  logic               game_over_q, game_over_d;
  logic               complete_q, complete_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic               rst_wait_q, rst_wait_d;
  logic               rst_idle_q, rst_idle_d;
  logic               rst_display_q, rst_display_d;

  logic               handshake;
  logic               pass_evt;
  logic               fail_evt;
  logic [SYM_W-1:0]   golden_sym;
  logic [3:0]         lives_dec;

  assign handshake  = sym_valid && (state_q == COLLECT);
  assign golden_sym = seq_mem[sym_idx_q*SYM_W +: SYM_W];
  assign lives_dec  = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;

  // Next-state and registered-output logic for the checking FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d         = state_q;
    round_d         = round_q;
    sym_idx_d       = sym_idx_q;
    timer_d         = timer_q;
    round_out_d     = round_out_q;
    lives_d         = lives_q;
    game_complete_d = game_complete_q;
    game_over_d     = game_over_q;
    complete_d      = 1'b0;
    fail_d          = 1'b0;
    timeout_d       = 1'b0;
    rst_wait_d      = 1'b0;
    rst_idle_d      = 1'b0;
    rst_display_d   = 1'b0;
    pass_evt        = 1'b0;
    fail_evt        = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_check) begin
          round_d   = (round_ctr_in > LAST_ROUND) ? LAST_ROUND : round_ctr_in;
          sym_idx_d = '0;
          timer_d   = '0;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (handshake) begin
          // A symbol on the timeout cycle is still judged on its value.
          if (sym_in != golden_sym) begin
            fail_evt = 1'b1;
          end else if (sym_idx_q == round_q) begin
            pass_evt = 1'b1;
          end else begin
            sym_idx_d = sym_idx_q + CTR_W'(1);
            timer_d   = '0;
          end
        end else if (timer_q == TMR_LAST) begin
          fail_evt  = 1'b1;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: ; // DONE is terminal until reset
    endcase

    if (pass_evt) begin
      complete_d    = 1'b1;
      rst_wait_d    = 1'b1;
      rst_display_d = 1'b1;
      rst_idle_d    = 1'b1;
      sym_idx_d     = '0;
      timer_d       = '0;
      if (round_q == LAST_ROUND) begin
        round_out_d     = round_q;
        game_complete_d = 1'b1;
        state_d         = DONE;
      end else begin
        round_out_d = round_q + CTR_W'(1);
        state_d     = IDLE;
      end
    end

    if (fail_evt) begin
      fail_d    = 1'b1;
      lives_d   = lives_dec;
      sym_idx_d = '0;
      timer_d   = '0;
      if (lives_dec == 4'd0) begin
        game_over_d = 1'b1;
        round_out_d = '0;
        state_d     = DONE;
      end else begin
        round_out_d   = round_q;   // replay the same round
        rst_display_d = 1'b1;
        state_d       = IDLE;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    if (rst_check) begin
      state_q         <= IDLE;
      round_q         <= '0;
      sym_idx_q       <= '0;
      timer_q         <= '0;
      round_out_q     <= '0;
      lives_q         <= LIVES_INIT;
      game_complete_q <= 1'b0;
      game_over_q     <= 1'b0;
      complete_q      <= 1'b0;
      fail_q          <= 1'b0;
      timeout_q       <= 1'b0;
      rst_wait_q      <= 1'b0;
      rst_idle_q      <= 1'b0;
      rst_display_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      round_q         <= round_d;
      sym_idx_q       <= sym_idx_d;
      timer_q         <= timer_d;
      round_out_q     <= round_out_d;
      lives_q         <= lives_d;
      game_complete_q <= game_complete_d;
      game_over_q     <= game_over_d;
      complete_q      <= complete_d;
      fail_q          <= fail_d;
      timeout_q       <= timeout_d;
      rst_wait_q      <= rst_wait_d;
      rst_idle_q      <= rst_idle_d;
      rst_display_q   <= rst_display_d;
    end
  end

  assign sym_ready      = (state_q == COLLECT);
  assign sym_idx        = sym_idx_q;
  assign round_ctr_out  = round_out_q;
  assign lives_left     = lives_q;
  assign complete_check = complete_q;
  assign fail_check     = fail_q;
  assign timeout_check  = timeout_q;
  assign game_complete  = game_complete_q;
  assign game_over      = game_over_q;
  assign rst_wait       = rst_wait_q;
  assign rst_idle       = rst_idle_q;
  assign rst_display    = rst_display_q;

endmodule

// File: tb/tb_seq_check_stream.sv
// Directed testbench for seq_check_stream (TIMEOUT=16, other parameters at
// defaults). A second instance with a widened round counter checks clamping.
module tb_seq_check_stream;

  localparam int SYM_W      = 2;
  localparam int MAX_ROUNDS = 16;
  localparam int LIVES      = 3;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst_check;
  logic        en_check, en_check_w;
  logic [3:0]  round_ctr_in;
  logic [4:0]  round_ctr_in_w;
  logic [SYM_W*MAX_ROUNDS-1:0] seq_mem;
  logic        sym_valid;
  logic [1:0]  sym_in;

  logic        sym_ready, complete_check, fail_check, timeout_check;
  logic        game_complete, game_over, rst_wait, rst_idle, rst_display;
  logic [3:0]  sym_idx, round_ctr_out, lives_left;

  logic        sym_ready_w, complete_check_w, fail_check_w, timeout_check_w;
  logic        game_complete_w, game_over_w, rst_wait_w, rst_idle_w, rst_display_w;
  logic [4:0]  sym_idx_w, round_ctr_out_w;
  logic [3:0]  lives_left_w;

  logic [1:0]  seq_syms [16];
  int          errors = 0;
  int          checks = 0;

  // {complete, wait, display, idle, fail, timeout}
  logic [5:0]  pulses;
  logic [20:0] obs_all;
  localparam logic [20:0] RESET_VEC = {1'b0, 4'd0, 4'd0, 4'd3, 8'd0};

  assign pulses  = {complete_check, rst_wait, rst_display, rst_idle, fail_check, timeout_check};
  assign obs_all = {sym_ready, sym_idx, round_ctr_out, lives_left,
                    complete_check, fail_check, timeout_check, game_complete,
                    game_over, rst_wait, rst_idle, rst_display};

  always #5 clk = ~clk;

  seq_check_stream #(
    .SYM_W(SYM_W), .MAX_ROUNDS(MAX_ROUNDS), .LIVES(LIVES), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst_check(rst_check), .en_check(en_check),
    .round_ctr_in(round_ctr_in), .seq_mem(seq_mem),
    .sym_valid(sym_valid), .sym_in(sym_in), .sym_ready(sym_ready),
    .sym_idx(sym_idx), .round_ctr_out(round_ctr_out), .lives_left(lives_left),
    .complete_check(complete_check), .fail_check(fail_check),
    .timeout_check(timeout_check), .game_complete(game_complete),
    .game_over(game_over), .rst_wait(rst_wait), .rst_idle(rst_idle),
    .rst_display(rst_display)
  );

  seq_check_stream #(
    .SYM_W(SYM_W), .MAX_ROUNDS(MAX_ROUNDS), .LIVES(LIVES), .TIMEOUT(TIMEOUT),
    .CTR_W(5)
  ) u_dut_wide (
    .clk(clk), .rst_check(rst_check), .en_check(en_check_w),
    .round_ctr_in(round_ctr_in_w), .seq_mem(seq_mem),
    .sym_valid(sym_valid), .sym_in(sym_in), .sym_ready(sym_ready_w),
    .sym_idx(sym_idx_w), .round_ctr_out(round_ctr_out_w), .lives_left(lives_left_w),
    .complete_check(complete_check_w), .fail_check(fail_check_w),
    .timeout_check(timeout_check_w), .game_complete(game_complete_w),
    .game_over(game_over_w), .rst_wait(rst_wait_w), .rst_idle(rst_idle_w),
    .rst_display(rst_display_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [3:0] r);
    round_ctr_in = r;
    en_check     = 1'b1;
    tick();
    en_check     = 1'b0;
  endtask

  task automatic send_sym(input logic [1:0] s);
    sym_valid = 1'b1;
    sym_in    = s;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_check = 1'b1;
    tick();
    rst_check = 1'b0;
  endtask

  task automatic test_reset();
    rst_check = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_all !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", obs_all, RESET_VEC);
    end
    rst_check = 1'b0;
    tick();
    checks++;
    if (obs_all !== RESET_VEC || {sym_ready_w, round_ctr_out_w} !== 6'd0) begin
      errors++;
      $display("FAIL reset_released: got %h/%h want %h/0", obs_all,
               {sym_ready_w, round_ctr_out_w}, RESET_VEC);
    end
  endtask

  task automatic test_pass();
    start_round(4'd2);
    checks++;
    if ({sym_ready, sym_idx} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL pass_enter: got %b want 10000", {sym_ready, sym_idx});
    end
    send_sym(2'd1);
    checks++;
    if ({sym_idx, pulses} !== {4'd1, 6'd0}) begin
      errors++;
      $display("FAIL pass_sym0: got %b want 0001000000", {sym_idx, pulses});
    end
    tick();
    checks++;
    if (pulses !== 6'd0) begin
      errors++;
      $display("FAIL pass_gap: pulses got %b want 000000", pulses);
    end
    send_sym(2'd3);
    tick();
    tick();
    checks++;
    if ({sym_idx, pulses} !== {4'd2, 6'd0}) begin
      errors++;
      $display("FAIL pass_sym1: got %b want 0010000000", {sym_idx, pulses});
    end
    send_sym(2'd0);
    checks++;
    if (pulses !== 6'b111100) begin
      errors++;
      $display("FAIL pass_pulses: got %b want 111100", pulses);
    end
    checks++;
    if ({round_ctr_out, lives_left, sym_ready, sym_idx} !== {4'd3, 4'd3, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL pass_state: round %0d lives %0d ready %b idx %0d want 3 3 0 0",
               round_ctr_out, lives_left, sym_ready, sym_idx);
    end
    tick();
    checks++;
    if ({pulses, round_ctr_out} !== {6'd0, 4'd3}) begin
      errors++;
      $display("FAIL pass_one_cycle: got %b want 0000000011", {pulses, round_ctr_out});
    end
  endtask

  task automatic test_fail();
    start_round(4'd2);
    send_sym(2'd1);
    send_sym(2'd2);
    checks++;
    if (pulses !== 6'b001010) begin
      errors++;
      $display("FAIL mismatch_pulses: got %b want 001010", pulses);
    end
    checks++;
    if ({lives_left, round_ctr_out, sym_ready, game_over} !== {4'd2, 4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mismatch_state: lives %0d round %0d ready %b over %b want 2 2 0 0",
               lives_left, round_ctr_out, sym_ready, game_over);
    end
    send_sym(2'd0);
    checks++;
    if ({sym_ready, sym_idx, pulses, lives_left} !== {1'b0, 4'd0, 6'd0, 4'd2}) begin
      errors++;
      $display("FAIL mismatch_no_accept: got %b want 0000000000010",
               {sym_ready, sym_idx, pulses, lives_left});
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    start_round(4'd0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (fail_check || timeout_check) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles want 16", n);
    end
    checks++;
    if ({pulses, lives_left, round_ctr_out} !== {6'b001011, 4'd1, 4'd0}) begin
      errors++;
      $display("FAIL timeout_state: got %b want 0010110001_0000",
               {pulses, lives_left, round_ctr_out});
    end
  endtask

  task automatic test_timeout_handshake();
    start_round(4'd0);
    repeat (15) tick();
    checks++;
    if ({sym_ready, pulses} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL timeout_edge_wait: got %b want 1000000", {sym_ready, pulses});
    end
    send_sym(seq_syms[0]);
    checks++;
    if ({pulses, round_ctr_out, lives_left} !== {6'b111100, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL timeout_edge_accept: got %b want 11110000010001",
               {pulses, round_ctr_out, lives_left});
    end
  endtask

  task automatic test_game_over();
    do_reset();
    start_round(4'd5);
    send_sym(2'd0);
    checks++;
    if ({lives_left, round_ctr_out, game_over} !== {4'd2, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL over_first: lives %0d round %0d over %b want 2 5 0",
               lives_left, round_ctr_out, game_over);
    end
    start_round(4'd5);
    send_sym(2'd0);
    start_round(4'd5);
    send_sym(2'd0);
    checks++;
    if (pulses !== 6'b000010) begin
      errors++;
      $display("FAIL over_pulses: got %b want 000010", pulses);
    end
    checks++;
    if ({game_over, lives_left, round_ctr_out, sym_ready} !== {1'b1, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL over_state: over %b lives %0d round %0d ready %b want 1 0 0 0",
               game_over, lives_left, round_ctr_out, sym_ready);
    end
    start_round(4'd3);
    send_sym(seq_syms[0]);
    tick();
    checks++;
    if ({game_over, lives_left, round_ctr_out, sym_ready, sym_idx, pulses}
        !== {1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 6'd0}) begin
      errors++;
      $display("FAIL over_sticky: over %b lives %0d ready %b pulses %b want 1 0 0 000000",
               game_over, lives_left, sym_ready, pulses);
    end
    do_reset();
    checks++;
    if (obs_all !== RESET_VEC) begin
      errors++;
      $display("FAIL over_reset: got %h want %h", obs_all, RESET_VEC);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    round_ctr_in   = 4'd15;
    round_ctr_in_w = 5'd20;
    en_check       = 1'b1;
    en_check_w     = 1'b1;
    tick();
    en_check       = 1'b0;
    en_check_w     = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send_sym(seq_syms[i]);
      checks++;
      if ({sym_idx, sym_idx_w, pulses, complete_check_w}
          !== {4'(i + 1), 5'(i + 1), 6'd0, 1'b0}) begin
        errors++;
        $display("FAIL b2b_idx%0d: idx %0d/%0d pulses %b want %0d/%0d 000000",
                 i, sym_idx, sym_idx_w, pulses, i + 1, i + 1);
      end
    end
    send_sym(seq_syms[15]);
    checks++;
    if ({pulses, game_complete, round_ctr_out, sym_ready} !== {6'b111100, 1'b1, 4'd15, 1'b0}) begin
      errors++;
      $display("FAIL final_round: pulses %b done %b round %0d ready %b want 111100 1 15 0",
               pulses, game_complete, round_ctr_out, sym_ready);
    end
    checks++;
    if ({complete_check_w, game_complete_w, round_ctr_out_w} !== {1'b1, 1'b1, 5'd15}) begin
      errors++;
      $display("FAIL clamp_round: cc %b done %b round %0d want 1 1 15",
               complete_check_w, game_complete_w, round_ctr_out_w);
    end
    tick();
    start_round(4'd3);
    send_sym(seq_syms[0]);
    checks++;
    if ({game_complete, pulses, sym_ready, round_ctr_out} !== {1'b1, 6'd0, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL final_sticky: done %b pulses %b ready %b round %0d want 1 000000 0 15",
               game_complete, pulses, sym_ready, round_ctr_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_round(4'd10);
    send_sym(2'd2);
    start_round(4'd10);
    for (int i = 0; i < 5; i++) send_sym(seq_syms[i]);
    checks++;
    if ({sym_idx, lives_left, sym_ready} !== {4'd5, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL mid_setup: idx %0d lives %0d ready %b want 5 2 1",
               sym_idx, lives_left, sym_ready);
    end
    rst_check = 1'b1;
    sym_valid = 1'b1;
    sym_in    = seq_syms[5];
    tick();
    rst_check = 1'b0;
    sym_valid = 1'b0;
    checks++;
    if (obs_all !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", obs_all, RESET_VEC);
    end
  endtask

  initial begin
    seq_syms = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3,
                 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    for (int i = 0; i < 16; i++) seq_mem[i*SYM_W +: SYM_W] = seq_syms[i];
    rst_check      = 1'b1;
    en_check       = 1'b0;
    en_check_w     = 1'b0;
    round_ctr_in   = 4'd0;
    round_ctr_in_w = 5'd0;
    sym_valid      = 1'b0;
    sym_in         = 2'd0;

    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_timeout_handshake();
    test_game_over();
    test_back_to_back();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/seq_check_stream.md
Name: seq_check_stream

Overview:
Parametrised successor to the round checker in the memory-game datapath. It checks player input one symbol at a time against the golden sequence, instead of comparing whole packed words once. It also adds a per-symbol timeout, a lives/retry budget and sticky end-of-game states. It sits between the input debouncer/encoder (symbol stream) and the top-level game FSM, and drives the same one-cycle block-reset pulses.

Parameters:
SYM_W, 2, bits per colour symbol (>=1)
MAX_ROUNDS, 16, rounds per game; round N needs N+1 symbols (>=2)
LIVES, 3, failed attempts allowed before game over (1..15)
TIMEOUT, 1024, idle cycles allowed between accepted symbols (>=2)
CTR_W, $clog2(MAX_ROUNDS), round counter width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_check  in  1  synchronous reset, active-high
en_check  in  1  start checking the round given by round_ctr_in (pulse)
round_ctr_in  in  CTR_W  round to check
seq_mem  in  SYM_W*MAX_ROUNDS  golden sequence; symbol i at bits [i*SYM_W +: SYM_W]
sym_valid  in  1  player symbol present
sym_in  in  SYM_W  player symbol
sym_ready  out  1  checker accepting symbols
sym_idx  out  CTR_W  index of next expected symbol
round_ctr_out  out  CTR_W  next round to play
lives_left  out  4  remaining lives
complete_check  out  1  one-cycle pulse: round passed
fail_check  out  1  one-cycle pulse: round failed (mismatch or timeout)
timeout_check  out  1  one-cycle pulse, coincident with fail_check when cause is timeout
game_complete  out  1  sticky: final round passed
game_over  out  1  sticky: lives exhausted
rst_wait, rst_idle  out  1  one-cycle pulses on success
rst_display  out  1  one-cycle pulse on success or on non-final failure (replay)

Behaviour:
- Reset: round_ctr_out=0, lives_left=LIVES, sym_idx=0, all pulses/sticky flags=0, sym_ready=0, state IDLE, timer=0. Reset has priority over every input. Reset mid-round aborts the round.
- States:
  - IDLE: sym_ready=0.
  - COLLECT: sym_ready=1.
  - DONE: sym_ready=0, terminal until rst_check.
- IDLE + en_check:
  - Latch round R = round_ctr_in, clamped to MAX_ROUNDS-1 if larger.
  - sym_idx=0, timer=0, next state COLLECT.
- COLLECT:
  - A handshake is sym_valid&&sym_ready.
  - Each handshake compares sym_in with seq_mem symbol sym_idx.
  - Mismatch -> FAIL.
  - Match with sym_idx==R -> PASS.
  - Match otherwise -> sym_idx+1, timer=0.
  - No handshake -> timer+1. When timer reaches TIMEOUT-1 without a handshake -> FAIL with timeout_check.
  - Handshake on the timeout cycle: the symbol is evaluated and the timeout is ignored.
- en_check while in COLLECT or DONE is ignored and does not relatch R.
- PASS (registered, outputs visible the cycle after the deciding handshake):
  - complete_check, rst_wait, rst_display and rst_idle pulse for one cycle.
  - If R==MAX_ROUNDS-1: round_ctr_out holds R, game_complete=1, state DONE.
  - Else: round_ctr_out=R+1, state IDLE.
  - lives_left unchanged.
- FAIL:
  - fail_check pulses; lives_left decrements.
  - If the decremented value is 0: game_over=1, round_ctr_out=0, state DONE, no rst_* pulses.
  - Else: round_ctr_out=R (replay same round), rst_display pulses, state IDLE.
- sym_idx returns to 0 on every exit from COLLECT.
- Outputs not named in the current transition hold their value. round_ctr_out never changes in IDLE.
- Pulses never last more than one cycle. complete_check and fail_check are never high together.
- No arithmetic wraps: round_ctr_out <= MAX_ROUNDS-1, lives_left >= 0, timer saturates.

Test Plan:
- Bench overrides: TIMEOUT=16, other parameters at defaults. Reset, then en_check with round_ctr_in=2 and seq_mem low symbols 1,3,0. Stream 1,3,0 with gaps -> complete_check, rst_wait, rst_display and rst_idle each pulse exactly once, one cycle after the 3rd handshake. round_ctr_out=3, lives_left=3.
- Round 2, stream 1,2 -> fail_check one cycle after the 2nd handshake. lives_left=2, round_ctr_out=2, rst_display pulses, rst_wait stays 0, state IDLE; the 3rd symbol is not accepted (sym_ready=0).
- en_check then no symbols -> fail_check and timeout_check pulse together 16 cycles after entry (TIMEOUT-1 idle cycles counted). Repeat with a valid symbol on the timeout cycle -> symbol accepted, no timeout.
- Three consecutive failures -> game_over=1, round_ctr_out=0, lives_left=0. Further en_check and sym_valid are ignored until rst_check, then all reset values return.
- round_ctr_in=15 with a full 16-symbol correct stream -> complete_check pulses, game_complete=1 sticky, round_ctr_out=15. round_ctr_in=20 with CTR_W widened by an override -> clamped to 15.
- Assert rst_check mid-stream at sym_idx=5 -> next cycle all outputs at reset values, sym_ready=0, lives_left=3.
